// File: rtl/moore_seq_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
package moore_seq_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} seq_state_t;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_GAP_CYCLES = 2;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, left-shifting register; the MSB is the serial output.
module seq_shift_reg
    import moore_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Load wins over shift so an accept always starts from a clean pattern.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign sout = shreg_q[WIDTH-1];

endmodule

// File: rtl/moore_seq_gen.sv
// Serial bit-pattern transmitter: MSB-first shift-out, idle gap, done pulse.
// Every output is decoded from registered state only.
module moore_seq_gen
    import moore_seq_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH+1)-1:0] len,
    output logic                       a,
    output logic                       a_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
    localparam logic [GW-1:0] GAP_L   = GW'(GAP_CYCLES);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [LW-1:0]    bitcnt_q;
    logic [LW-1:0]    bitcnt_d;
    logic [GW-1:0]    gapcnt_q;
    logic [GW-1:0]    gapcnt_d;
    logic [LW-1:0]    len_clamped;
    logic [WIDTH-1:0] aligned;
    logic             load;
    logic             shift;
    logic             sout;

    // Left-align so the first bit to send always sits in the MSB.
    assign len_clamped = (len > WIDTH_L) ? WIDTH_L : len;
    assign aligned     = pattern << (WIDTH_L - len_clamped);

    seq_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (aligned),
        .sout  (sout)
    );

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        load     = 1'b0;
        shift    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    load     = 1'b1;
                    bitcnt_d = len_clamped;
                    state_d  = (len_clamped != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                shift    = 1'b1;
                bitcnt_d = bitcnt_q - LW'(1);
                if (bitcnt_q == LW'(1)) begin
                    gapcnt_d = GAP_L;
                    state_d  = (GAP_CYCLES > 0) ? GAP : DONE;
                end
            end
            GAP: begin
                gapcnt_d = gapcnt_q - GW'(1);
                if (gapcnt_q == GW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign a_valid     = (state_q == SHIFT);
    assign a           = (state_q == SHIFT) && sout;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Scoreboard bench: stimulus queues expected bits/transfers, a monitor checks them.
module tb_moore_seq_gen;

    localparam int WIDTH = 8;
    localparam int GAP   = 2;
    localparam int LW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] pattern = '0;
    logic [LW-1:0]    len = '0;
    logic             a;
    logic             a_valid;
    logic             busy;
    logic             done;

    typedef struct {
        int n;
        int gap;
        int lat;
        int period;
    } xfer_t;

    logic  exp_bits[$];
    xfer_t exp_xfer[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;

    xfer_t cur;
    bit    cur_active = 1'b0;
    int    acc_cyc = 0;
    int    n_valid = 0;
    int    n_idle = 0;
    logic  exp_b;

    moore_seq_gen #(
        .WIDTH      (WIDTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .len         (len),
        .a           (a),
        .a_valid     (a_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bits(input logic [7:0] bits, input int n);
        logic [7:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) exp_bits.push_back(b[i]);
    endtask

    task automatic push_xfer(input int n, input int period);
        xfer_t x;
        x.n      = n;
        x.gap    = (n != 0) ? GAP : 0;
        x.lat    = (n != 0) ? n + GAP + 1 : 1;
        x.period = period;
        exp_xfer.push_back(x);
    endtask

    task automatic wait_accept();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (start_ready && reset) break;
        end
        if (k == 200) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 200) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] pat, input int l, input logic [7:0] bits, input int n);
        push_bits(bits, n);
        push_xfer(n, 0);
        pattern     = pat;
        len         = LW'(l);
        start_valid = 1'b1;
        wait_accept();
        start_valid = 1'b0;
        wait_done();
    endtask

    // Monitor: checks every cycle against the queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                chk("rst_a", a, 0);
                chk("rst_a_valid", a_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_ready", start_ready, 1);
                cur_active = 1'b0;
            end else if (cur_active) begin
                chk("busy_hi", busy, 1);
                chk("ready_lo", start_ready, 0);
                if (a_valid) begin
                    if (exp_bits.size() == 0) begin
                        chk("bit_expected", 0, 1);
                    end else begin
                        exp_b = exp_bits.pop_front();
                        chk("a_bit", a, exp_b);
                    end
                    if (n_valid == 0) chk("first_bit_lat", cyc - acc_cyc, 1);
                    n_valid++;
                end else begin
                    chk("a_idle_zero", a, 0);
                    if (!done) n_idle++;
                end
                if (done) begin
                    chk("n_bits", n_valid, cur.n);
                    chk("gap_cycles", n_idle, cur.gap);
                    chk("done_lat", cyc - acc_cyc, cur.lat);
                    $display("[TB] transfer len=%0d bits=%0d gap=%0d done_lat=%0d",
                             cur.n, n_valid, n_idle, cyc - acc_cyc);
                    cur_active = 1'b0;
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_a_valid", a_valid, 0);
                chk("idle_a", a, 0);
                chk("idle_done", done, 0);
                chk("idle_ready", start_ready, 1);
                if (start_valid) begin
                    if (exp_xfer.size() == 0) begin
                        chk("xfer_expected", 0, 1);
                    end else begin
                        cur = exp_xfer.pop_front();
                        if (cur.period != 0) chk("b2b_period", cyc - acc_cyc, cur.period);
                        acc_cyc    = cyc;
                        cur_active = 1'b1;
                        n_valid    = 0;
                        n_idle     = 0;
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1 start_valid = ~start_valid;
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        #1;

        send(8'b1011_0010, 8, 8'b1011_0010, 8);
        send(8'b1111_1101, 3, 8'b0000_0101, 3);
        send(8'b0110_1001, 9, 8'b0110_1001, 8);
        send(8'hFF,        0, 8'h00,        0);
        send(8'hFE,        1, 8'h00,        1);
        send(8'b1011_0011, 5, 8'b0001_0011, 5);

        // Back-to-back with start_valid held high through the first transfer.
        push_bits(8'b1011_0010, 8);
        push_xfer(8, 0);
        push_bits(8'b0101_1101, 8);
        push_xfer(8, 8 + GAP + 2);
        pattern     = 8'b1011_0010;
        len         = LW'(8);
        start_valid = 1'b1;
        wait_accept();
        pattern     = 8'b0101_1101;
        wait_done();
        wait_accept();
        start_valid = 1'b0;
        wait_done();

        // Reset after the third bit of a full-width transfer.
        push_bits(8'b0000_0101, 3);
        push_xfer(8, 0);
        pattern     = 8'b1011_0010;
        len         = LW'(8);
        start_valid = 1'b1;
        wait_accept();
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        send(8'b1100_1010, 8, 8'b1100_1010, 8);

        repeat (3) @(posedge clk);
        #1;
        chk("bits_left", exp_bits.size(), 0);
        chk("xfers_left", exp_xfer.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
